// File: rtl/ant_farm_pkg.sv
// Shared encodings for the ant-farm grid: command codes, cell types, contents
// and the scheduler state enum.
package ant_farm_pkg;

    localparam int CMD_W = 5;

    typedef enum logic [CMD_W-1:0] {
        CMD_NOP           = 5'd0,
        CMD_SET_EMPTY     = 5'd1,
        CMD_SET_GROUND    = 5'd2,
        CMD_SET_TUNNEL    = 5'd3,
        CMD_SET_QUEEN     = 5'd4,
        CMD_SET_NONE      = 5'd5,
        CMD_SET_ANT       = 5'd6,
        CMD_SET_SUGAR     = 5'd7,
        CMD_SET_SUGAR_ANT = 5'd8,
        CMD_STEP          = 5'd9
    } cmd_e;

    typedef enum logic [1:0] {
        CELL_E = 2'd0,
        CELL_G = 2'd1,
        CELL_T = 2'd2,
        CELL_Q = 2'd3
    } cell_type_e;

    typedef enum logic [1:0] {
        CONT_NONE      = 2'd0,
        CONT_ANT       = 2'd1,
        CONT_SUGAR     = 2'd2,
        CONT_SUGAR_ANT = 2'd3
    } contents_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_e;

    // Host may issue any real command; NOP is meaningless and STEP belongs to the sweep.
    function automatic logic host_cmd_legal(input logic [CMD_W-1:0] cmd);
        return (cmd != CMD_NOP) && (cmd < CMD_STEP);
    endfunction

endpackage

// File: rtl/grid_raster_counter.sv
// Raster-order cell walker: x runs fastest, wrapping into y; last flags the final cell.
module grid_raster_counter #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 12,
    parameter int XW     = 4,
    parameter int YW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no branch infers a latch.
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (en) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x    = x_q;
    assign y    = y_q;
    assign last = (x_q == X_MAX) && (y_q == Y_MAX);

endmodule

// File: rtl/ant_grid_scheduler.sv
// Arbitrates the grid command slot between single host commands and the
// per-tick raster STEP sweep; the slot toward the grid is a registered valid/ready stage.
module ant_grid_scheduler
    import ant_farm_pkg::*;
#(
    parameter int GRID_W = 16,
    parameter int GRID_H = 12,
    parameter int XW     = 4,
    parameter int YW     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             host_valid,
    output logic             host_ready,
    input  logic [CMD_W-1:0] host_cmd,
    input  logic [XW-1:0]    host_x,
    input  logic [YW-1:0]    host_y,
    output logic             grid_valid,
    input  logic             grid_ready,
    output logic [CMD_W-1:0] grid_cmd,
    output logic [XW-1:0]    grid_x,
    output logic [YW-1:0]    grid_y,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic [15:0]      gen_count,
    output logic             tick_overrun,
    input  logic             clear_overrun,
    output logic             bad_cmd
);

    localparam logic [XW:0] X_LIM = (XW + 1)'(GRID_W);
    localparam logic [YW:0] Y_LIM = (YW + 1)'(GRID_H);

    sched_state_e     state_q, state_d;
    logic             grid_valid_q, grid_valid_d;
    logic [CMD_W-1:0] grid_cmd_q, grid_cmd_d;
    logic [XW-1:0]    grid_x_q, grid_x_d;
    logic [YW-1:0]    grid_y_q, grid_y_d;
    logic             sweep_busy_q, sweep_busy_d;
    logic             sweep_done_q, sweep_done_d;
    logic [15:0]      gen_count_q, gen_count_d;
    logic             tick_overrun_q, tick_overrun_d;
    logic             bad_cmd_q, bad_cmd_d;
    logic             tick_pend_q, tick_pend_d;

    logic             slot_free;
    logic             host_fire;
    logic             host_legal;
    logic             step_en;
    logic             raster_clr;
    logic [XW-1:0]    raster_x;
    logic [YW-1:0]    raster_y;
    logic             raster_last;

    grid_raster_counter #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .XW     (XW),
        .YW     (YW)
    ) u_raster (
        .clk  (clk),
        .rst  (rst),
        .en   (step_en),
        .clr  (raster_clr),
        .x    (raster_x),
        .y    (raster_y),
        .last (raster_last)
    );

    assign slot_free  = !grid_valid_q || grid_ready;
    assign host_ready = (state_q == ST_IDLE) && !tick && !tick_pend_q && slot_free;
    assign host_fire  = host_valid && host_ready;
    assign host_legal = host_cmd_legal(host_cmd)
                     && ({1'b0, host_x} < X_LIM)
                     && ({1'b0, host_y} < Y_LIM);

    always_comb begin
        state_d        = state_q;
        grid_valid_d   = grid_valid_q && !grid_ready;
        grid_cmd_d     = grid_cmd_q;
        grid_x_d       = grid_x_q;
        grid_y_d       = grid_y_q;
        sweep_busy_d   = sweep_busy_q;
        sweep_done_d   = 1'b0;
        gen_count_d    = gen_count_q;
        tick_overrun_d = tick_overrun_q;
        bad_cmd_d      = 1'b0;
        tick_pend_d    = tick_pend_q;
        step_en        = 1'b0;
        raster_clr     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (tick || tick_pend_q) begin
                    if (slot_free) begin
                        // First STEP is loaded on the start edge itself for 1-cycle latency.
                        grid_valid_d = 1'b1;
                        grid_cmd_d   = CMD_STEP;
                        grid_x_d     = raster_x;
                        grid_y_d     = raster_y;
                        step_en      = 1'b1;
                        sweep_busy_d = 1'b1;
                        tick_pend_d  = 1'b0;
                        state_d      = raster_last ? ST_DRAIN : ST_SWEEP;
                    end else begin
                        tick_pend_d = 1'b1;
                    end
                end else if (host_fire) begin
                    if (host_legal) begin
                        grid_valid_d = 1'b1;
                        grid_cmd_d   = host_cmd;
                        grid_x_d     = host_x;
                        grid_y_d     = host_y;
                    end else begin
                        bad_cmd_d = 1'b1;
                    end
                end
            end
            ST_SWEEP: begin
                if (slot_free) begin
                    grid_valid_d = 1'b1;
                    grid_cmd_d   = CMD_STEP;
                    grid_x_d     = raster_x;
                    grid_y_d     = raster_y;
                    step_en      = 1'b1;
                    if (raster_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (grid_valid_q && grid_ready) begin
                    sweep_done_d = 1'b1;
                    gen_count_d  = gen_count_q + 16'd1;
                    sweep_busy_d = 1'b0;
                    raster_clr   = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A tick during a sweep is dropped; set beats a simultaneous clear.
        if (tick && (state_q != ST_IDLE)) begin
            tick_overrun_d = 1'b1;
        end else if (clear_overrun) begin
            tick_overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            grid_valid_q   <= 1'b0;
            grid_cmd_q     <= '0;
            grid_x_q       <= '0;
            grid_y_q       <= '0;
            sweep_busy_q   <= 1'b0;
            sweep_done_q   <= 1'b0;
            gen_count_q    <= '0;
            tick_overrun_q <= 1'b0;
            bad_cmd_q      <= 1'b0;
            tick_pend_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            grid_valid_q   <= grid_valid_d;
            grid_cmd_q     <= grid_cmd_d;
            grid_x_q       <= grid_x_d;
            grid_y_q       <= grid_y_d;
            sweep_busy_q   <= sweep_busy_d;
            sweep_done_q   <= sweep_done_d;
            gen_count_q    <= gen_count_d;
            tick_overrun_q <= tick_overrun_d;
            bad_cmd_q      <= bad_cmd_d;
            tick_pend_q    <= tick_pend_d;
        end
    end

    assign grid_valid   = grid_valid_q;
    assign grid_cmd     = grid_cmd_q;
    assign grid_x       = grid_x_q;
    assign grid_y       = grid_y_q;
    assign sweep_busy   = sweep_busy_q;
    assign sweep_done   = sweep_done_q;
    assign gen_count    = gen_count_q;
    assign tick_overrun = tick_overrun_q;
    assign bad_cmd      = bad_cmd_q;

endmodule

// File: tb/tb_ant_grid_scheduler.sv
// Self-checking bench for ant_grid_scheduler on a 4x2 grid; transfers seen on
// the grid port are collected and compared against a raster/legality model.
module tb_ant_grid_scheduler;
    import ant_farm_pkg::*;

    localparam int GW    = 4;
    localparam int GH    = 2;
    localparam int XW    = 4;
    localparam int YW    = 4;
    localparam int NCELL = GW * GH;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic          host_valid;
    logic          host_ready;
    logic [4:0]    host_cmd;
    logic [XW-1:0] host_x;
    logic [YW-1:0] host_y;
    logic          grid_valid;
    logic          grid_ready;
    logic [4:0]    grid_cmd;
    logic [XW-1:0] grid_x;
    logic [YW-1:0] grid_y;
    logic          sweep_busy;
    logic          sweep_done;
    logic [15:0]   gen_count;
    logic          tick_overrun;
    logic          clear_overrun;
    logic          bad_cmd;

    logic [12:0]   slot;
    logic [12:0]   seen_q[$];
    int            bad_seen = 0;
    int            n_checks = 0;
    int            n_errors = 0;
    int            exp_gen  = 0;

    assign slot = {grid_cmd, grid_x, grid_y};

    always #5 clk = ~clk;

    ant_grid_scheduler #(
        .GRID_W (GW),
        .GRID_H (GH),
        .XW     (XW),
        .YW     (YW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .tick          (tick),
        .host_valid    (host_valid),
        .host_ready    (host_ready),
        .host_cmd      (host_cmd),
        .host_x        (host_x),
        .host_y        (host_y),
        .grid_valid    (grid_valid),
        .grid_ready    (grid_ready),
        .grid_cmd      (grid_cmd),
        .grid_x        (grid_x),
        .grid_y        (grid_y),
        .sweep_busy    (sweep_busy),
        .sweep_done    (sweep_done),
        .gen_count     (gen_count),
        .tick_overrun  (tick_overrun),
        .clear_overrun (clear_overrun),
        .bad_cmd       (bad_cmd)
    );

    // Inputs change 1ns after posedge, so at negedge the upcoming handshake is settled.
    always @(negedge clk) begin
        if (!rst && grid_valid && grid_ready) seen_q.push_back(slot);
        if (!rst && bad_cmd) bad_seen++;
    end

    function automatic logic [12:0] exp_step(input int i);
        return {5'd9, 4'(i % GW), 4'(i / GW)};
    endfunction

    function automatic bit legal(input int c, input int x, input int y);
        return (c >= 1) && (c <= 8) && (x < GW) && (y < GH);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One tick-started sweep; optional ready stalls, random ready, extra tick/clear at cycle k.
    task automatic run_sweep(input bit rand_ready, input int lo, input int hi,
                             input int tick_at, input int clr_at,
                             output int done_k, output int unstable,
                             output int hr_bad, output logic [12:0] held);
        int k;
        seen_q.delete();
        grid_ready = 1'b1;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        k = 1; done_k = -1; unstable = 0; hr_bad = 0; held = '0;
        while (done_k < 0 && k < 400) begin
            if (rand_ready) grid_ready = ($urandom_range(0, 2) != 0);
            else            grid_ready = !(k >= lo && k <= hi);
            tick          = (k == tick_at);
            clear_overrun = (k == clr_at);
            #1;
            if (sweep_busy && host_ready) hr_bad++;
            if (k == lo) held = slot;
            else if (k > lo && k <= hi && slot !== held) unstable++;
            cyc();
            k++;
            if (sweep_done) done_k = k;
        end
        tick = 1'b0;
        clear_overrun = 1'b0;
        grid_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick = 0; host_valid = 0; host_cmd = 0; host_x = 0; host_y = 0;
        grid_ready = 1'b1; clear_overrun = 0;
        #20;
        n_checks++;
        if ({grid_valid, grid_cmd, grid_x, grid_y, sweep_busy, sweep_done, gen_count,
             tick_overrun, bad_cmd} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got valid=%b cmd=%0d x=%0d y=%0d busy=%b done=%b gen=%0d ovr=%b bad=%b, want all 0",
                     grid_valid, grid_cmd, grid_x, grid_y, sweep_busy, sweep_done, gen_count, tick_overrun, bad_cmd);
        end
        @(posedge clk); #1 rst = 1'b0;
        cyc();
    endtask

    task automatic test_host_single();
        seen_q.delete();
        host_valid = 1; host_cmd = 5'd3; host_x = 4'd2; host_y = 4'd1;
        #1;
        n_checks++;
        if (host_ready !== 1'b1) begin
            n_errors++; $display("FAIL host_ready_idle: got %b want 1", host_ready);
        end
        cyc();
        host_valid = 0;
        n_checks++;
        if ({grid_valid, slot} !== {1'b1, 5'd3, 4'd2, 4'd1}) begin
            n_errors++; $display("FAIL host_slot: got v=%b slot=%h want v=1 slot=%h", grid_valid, slot, {5'd3, 4'd2, 4'd1});
        end
        n_checks++;
        if (bad_cmd !== 1'b0) begin
            n_errors++; $display("FAIL host_bad_cmd: got %b want 0", bad_cmd);
        end
        cyc();
        n_checks++;
        if (grid_valid !== 1'b0 || seen_q.size() != 1) begin
            n_errors++; $display("FAIL host_one_cycle: got v=%b transfers=%0d want v=0 transfers=1", grid_valid, seen_q.size());
        end
    endtask

    task automatic test_sweep_basic();
        int done_k, unstable, hr_bad;
        logic [12:0] held;
        run_sweep(0, 0, -1, -1, -1, done_k, unstable, hr_bad, held);
        exp_gen++;
        n_checks++;
        if (done_k != NCELL + 1) begin
            n_errors++; $display("FAIL basic_done_cycle: got %0d want %0d", done_k, NCELL + 1);
        end
        n_checks++;
        if (hr_bad != 0) begin
            n_errors++; $display("FAIL basic_host_ready: got %0d busy cycles with ready want 0", hr_bad);
        end
        n_checks++;
        if (seen_q.size() != NCELL) begin
            n_errors++; $display("FAIL basic_count: got %0d want %0d", seen_q.size(), NCELL);
        end
        for (int i = 0; i < NCELL && i < seen_q.size(); i++) begin
            n_checks++;
            if (seen_q[i] !== exp_step(i)) begin
                n_errors++; $display("FAIL basic_seq[%0d]: got %h want %h", i, seen_q[i], exp_step(i));
            end
        end
        n_checks++;
        if (gen_count !== 16'(exp_gen)) begin
            n_errors++; $display("FAIL basic_gen: got %0d want %0d", gen_count, exp_gen);
        end
        cyc();
        n_checks++;
        if (sweep_done !== 1'b0 || sweep_busy !== 1'b0) begin
            n_errors++; $display("FAIL basic_after: got done=%b busy=%b want 0 0", sweep_done, sweep_busy);
        end
    endtask

    task automatic test_stall();
        int done_k, unstable, hr_bad;
        logic [12:0] held;
        run_sweep(0, 3, 5, -1, -1, done_k, unstable, hr_bad, held);
        exp_gen++;
        n_checks++;
        if (held !== exp_step(2) || unstable != 0) begin
            n_errors++; $display("FAIL stall_hold: got %h (changes %0d) want %h stable", held, unstable, exp_step(2));
        end
        n_checks++;
        if (done_k != NCELL + 1 + 3) begin
            n_errors++; $display("FAIL stall_done_cycle: got %0d want %0d", done_k, NCELL + 4);
        end
        n_checks++;
        if (seen_q.size() != NCELL) begin
            n_errors++; $display("FAIL stall_count: got %0d want %0d", seen_q.size(), NCELL);
        end
        for (int i = 0; i < NCELL && i < seen_q.size(); i++) begin
            n_checks++;
            if (seen_q[i] !== exp_step(i)) begin
                n_errors++; $display("FAIL stall_seq[%0d]: got %h want %h", i, seen_q[i], exp_step(i));
            end
        end
    endtask

    task automatic test_random_stall();
        int done_k, unstable, hr_bad;
        logic [12:0] held;
        for (int r = 0; r < 3; r++) begin
            run_sweep(1, 0, -1, -1, -1, done_k, unstable, hr_bad, held);
            exp_gen++;
            n_checks++;
            if (done_k < 0 || seen_q.size() != NCELL) begin
                n_errors++; $display("FAIL rand_stall_count[%0d]: got done=%0d transfers=%0d want done and %0d", r, done_k, seen_q.size(), NCELL);
            end
            for (int i = 0; i < NCELL && i < seen_q.size(); i++) begin
                n_checks++;
                if (seen_q[i] !== exp_step(i)) begin
                    n_errors++; $display("FAIL rand_stall_seq[%0d][%0d]: got %h want %h", r, i, seen_q[i], exp_step(i));
                end
            end
        end
        n_checks++;
        if (gen_count !== 16'(exp_gen)) begin
            n_errors++; $display("FAIL rand_stall_gen: got %0d want %0d", gen_count, exp_gen);
        end
    endtask

    task automatic test_overrun();
        int done_k, unstable, hr_bad;
        logic [12:0] held;
        run_sweep(0, 0, -1, 3, -1, done_k, unstable, hr_bad, held);
        exp_gen++;
        n_checks++;
        if (tick_overrun !== 1'b1 || done_k != NCELL + 1) begin
            n_errors++; $display("FAIL overrun_set: got ovr=%b done=%0d want 1 %0d", tick_overrun, done_k, NCELL + 1);
        end
        cyc(); cyc();
        n_checks++;
        if (grid_valid !== 1'b0 || sweep_busy !== 1'b0) begin
            n_errors++; $display("FAIL overrun_not_queued: got v=%b busy=%b want 0 0", grid_valid, sweep_busy);
        end
        run_sweep(0, 0, -1, 4, 4, done_k, unstable, hr_bad, held);
        exp_gen++;
        n_checks++;
        if (tick_overrun !== 1'b1) begin
            n_errors++; $display("FAIL overrun_set_wins: got %b want 1", tick_overrun);
        end
        n_checks++;
        if (gen_count !== 16'(exp_gen)) begin
            n_errors++; $display("FAIL overrun_gen: got %0d want %0d", gen_count, exp_gen);
        end
        clear_overrun = 1'b1;
        cyc();
        clear_overrun = 1'b0;
        n_checks++;
        if (tick_overrun !== 1'b0) begin
            n_errors++; $display("FAIL overrun_clear: got %b want 0", tick_overrun);
        end
    endtask

    task automatic test_bad_cmds();
        int cmds[5] = '{0, 9, 3, 1, 0};
        int xs[5]   = '{1, 1, 5, 0, 0};
        int ys[5]   = '{1, 1, 0, 2, 0};
        seen_q.delete();
        cmds[4] = $urandom_range(10, 31);
        for (int i = 0; i < 5; i++) begin
            host_valid = 1; host_cmd = 5'(cmds[i]); host_x = 4'(xs[i]); host_y = 4'(ys[i]);
            #1;
            n_checks++;
            if (host_ready !== 1'b1) begin
                n_errors++; $display("FAIL bad_ready[%0d]: got %b want 1", i, host_ready);
            end
            cyc();
            host_valid = 0;
            n_checks++;
            if (bad_cmd !== 1'b1 || grid_valid !== 1'b0) begin
                n_errors++; $display("FAIL bad_pulse[%0d]: got bad=%b v=%b want 1 0", i, bad_cmd, grid_valid);
            end
            cyc();
            n_checks++;
            if (bad_cmd !== 1'b0) begin
                n_errors++; $display("FAIL bad_one_cycle[%0d]: got %b want 0", i, bad_cmd);
            end
        end
        n_checks++;
        if (seen_q.size() != 0) begin
            n_errors++; $display("FAIL bad_no_transfer: got %0d want 0", seen_q.size());
        end
    endtask

    task automatic test_tick_vs_host();
        int k;
        seen_q.delete();
        host_valid = 1; host_cmd = 5'd1; host_x = 4'd1; host_y = 4'd1; tick = 1;
        #1;
        n_checks++;
        if (host_ready !== 1'b0) begin
            n_errors++; $display("FAIL tick_prio_ready: got %b want 0", host_ready);
        end
        cyc();
        tick = 0; host_valid = 0;
        n_checks++;
        if ({grid_valid, slot} !== {1'b1, exp_step(0)}) begin
            n_errors++; $display("FAIL tick_prio_first: got v=%b slot=%h want v=1 slot=%h", grid_valid, slot, exp_step(0));
        end
        k = 0;
        while (!sweep_done && k < 100) begin cyc(); k++; end
        exp_gen++;
        n_checks++;
        if (seen_q.size() != NCELL || seen_q[0] !== exp_step(0) || seen_q[NCELL-1] !== exp_step(NCELL-1)) begin
            n_errors++; $display("FAIL tick_prio_seq: got %0d transfers want %0d steps only", seen_q.size(), NCELL);
        end
    endtask

    task automatic test_tick_pend();
        int k;
        seen_q.delete();
        grid_ready = 0;
        host_valid = 1; host_cmd = 5'd2; host_x = 4'd1; host_y = 4'd0;
        cyc();
        host_valid = 0;
        tick = 1;
        cyc();
        tick = 0;
        cyc();
        n_checks++;
        if (sweep_busy !== 1'b0 || slot !== {5'd2, 4'd1, 4'd0} || grid_valid !== 1'b1) begin
            n_errors++; $display("FAIL pend_hold: got busy=%b v=%b slot=%h want 0 1 %h", sweep_busy, grid_valid, slot, {5'd2, 4'd1, 4'd0});
        end
        grid_ready = 1;
        k = 0;
        while (!sweep_done && k < 100) begin cyc(); k++; end
        exp_gen++;
        n_checks++;
        if (seen_q.size() != NCELL + 1) begin
            n_errors++; $display("FAIL pend_count: got %0d want %0d", seen_q.size(), NCELL + 1);
        end else begin
            for (int i = 1; i <= NCELL; i++) begin
                n_checks++;
                if (seen_q[i] !== exp_step(i - 1)) begin
                    n_errors++; $display("FAIL pend_seq[%0d]: got %h want %h", i, seen_q[i], exp_step(i - 1));
                end
            end
        end
    endtask

    task automatic test_random_host();
        logic [12:0] exp_q[$];
        int exp_bad, bad0, c, x, y, w;
        seen_q.delete();
        exp_bad = 0;
        bad0 = bad_seen;
        for (int n = 0; n < 40; n++) begin
            c = $urandom_range(0, 15); x = $urandom_range(0, 5); y = $urandom_range(0, 3);
            host_valid = 1; host_cmd = 5'(c); host_x = 4'(x); host_y = 4'(y);
            w = 0;
            forever begin
                grid_ready = ($urandom_range(0, 1) != 0);
                #1;
                if (host_ready || w > 50) break;
                cyc(); w++;
            end
            cyc();
            host_valid = 0;
            if (w > 50) begin
                n_checks++; n_errors++;
                $display("FAIL rand_host_timeout[%0d]: got no host_ready want accept", n);
            end else if (legal(c, x, y)) exp_q.push_back({5'(c), 4'(x), 4'(y)});
            else exp_bad++;
        end
        grid_ready = 1;
        cyc(); cyc();
        n_checks++;
        if (seen_q.size() != exp_q.size()) begin
            n_errors++; $display("FAIL rand_host_count: got %0d want %0d", seen_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (seen_q[i] !== exp_q[i]) begin
                    n_errors++; $display("FAIL rand_host_seq[%0d]: got %h want %h", i, seen_q[i], exp_q[i]);
                end
            end
        end
        n_checks++;
        if (bad_seen - bad0 != exp_bad) begin
            n_errors++; $display("FAIL rand_host_bad: got %0d want %0d", bad_seen - bad0, exp_bad);
        end
    endtask

    task automatic test_reset_mid();
        int done_k, unstable, hr_bad;
        logic [12:0] held;
        seen_q.delete();
        tick = 1;
        cyc();
        tick = 0;
        repeat (4) cyc();
        n_checks++;
        if (slot !== exp_step(4)) begin
            n_errors++; $display("FAIL mid_fifth_step: got %h want %h", slot, exp_step(4));
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({grid_valid, grid_cmd, grid_x, grid_y, sweep_busy, sweep_done, gen_count,
             tick_overrun, bad_cmd} !== '0) begin
            n_errors++; $display("FAIL mid_reset_async: got v=%b slot=%h busy=%b gen=%0d want all 0", grid_valid, slot, sweep_busy, gen_count);
        end
        @(posedge clk); #1 rst = 1'b0;
        exp_gen = 0;
        cyc();
        n_checks++;
        if (grid_valid !== 1'b0 || sweep_busy !== 1'b0) begin
            n_errors++; $display("FAIL mid_no_resume: got v=%b busy=%b want 0 0", grid_valid, sweep_busy);
        end
        run_sweep(0, 0, -1, -1, -1, done_k, unstable, hr_bad, held);
        exp_gen++;
        n_checks++;
        if (seen_q.size() != NCELL) begin
            n_errors++; $display("FAIL mid_restart_count: got %0d want %0d", seen_q.size(), NCELL);
        end
        for (int i = 0; i < NCELL && i < seen_q.size(); i++) begin
            n_checks++;
            if (seen_q[i] !== exp_step(i)) begin
                n_errors++; $display("FAIL mid_restart_seq[%0d]: got %h want %h", i, seen_q[i], exp_step(i));
            end
        end
        n_checks++;
        if (gen_count !== 16'(exp_gen)) begin
            n_errors++; $display("FAIL mid_gen: got %0d want %0d", gen_count, exp_gen);
        end
    endtask

    initial begin
        test_reset();
        test_host_single();
        test_sweep_basic();
        test_stall();
        test_random_stall();
        test_overrun();
        test_bad_cmds();
        test_tick_vs_host();
        test_tick_pend();
        test_random_host();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
